// File: rtl/divider.sv
// rtl/divider.sv - iterative signed restoring divider with start/ready pulse handshake (optional DIV_EARLY_EXIT_EN)
module divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  state_t           start_state;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] b_mag;
  logic             sign_a;
  logic             neg;
  logic             exc;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             start_exc;
  logic             last_iter;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_nx;

  // Operand magnitudes and exception detection for the start edge; |0x80000000| stays 0x80000000 as unsigned 2^31
  always_comb begin
    a_abs     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_abs     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    start_exc = (data_operandB == '0) ||
                ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1));
`ifdef DIV_EARLY_EXIT_EN
    start_state = start_exc ? DONE : RUN;
`else
    start_state = RUN;
`endif
  end

  // One restoring step: shift {R,Q} left, trial-subtract |B| one bit wider so the sign bit is exact
  always_comb begin
    diff   = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_mag};
    fits   = ~diff[WIDTH];
    quo_nx = {quo_q[WIDTH-2:0], fits};
    rem_nx = fits ? diff[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  end

  assign last_iter      = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign data_resultRDY = (state == DONE);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: a start pulse wins from any state, otherwise RUN counts out to DONE and DONE lasts one cycle
  always_comb begin
    state_nx = state;
    if (ctrl_DIV) begin
      state_nx = start_state;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        RUN:     state_nx = last_iter ? DONE : RUN;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath: load on start, iterate in RUN, register the sign-fixed results on the final iteration
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      b_mag          <= '0;
      sign_a         <= 1'b0;
      neg            <= 1'b0;
      exc            <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      cnt    <= '0;
      quo_q  <= a_abs;
      rem_q  <= '0;
      b_mag  <= b_abs;
      sign_a <= data_operandA[WIDTH-1];
      neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      exc    <= start_exc;
`ifdef DIV_EARLY_EXIT_EN
      if (start_exc) begin
        data_result    <= '0;
        data_remainder <= '0;
        data_exception <= 1'b1;
      end
`endif
    end else if (state == RUN) begin
      cnt   <= cnt + CNT_W'(1);
      quo_q <= quo_nx;
      rem_q <= rem_nx;
      if (last_iter) begin
        if (exc) begin
          data_result    <= '0;
          data_remainder <= '0;
          data_exception <= 1'b1;
        end else begin
          data_result    <= neg ? -quo_nx : quo_nx;
          data_remainder <= sign_a ? -rem_nx : rem_nx;
          data_exception <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider against a plain-arithmetic reference model
module tb_divider;

  logic        clk;
  logic        rst_n;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        start;
  logic [31:0] res;
  logic [31:0] rem;
  logic        exc;
  logic        rdy;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EXC_LAT = 1;
`else
  localparam int EXC_LAT = 33;
`endif

  logic [31:0] prev_res;

  divider dut (
    .clock          (clk),
    .reset          (rst_n),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_DIV       (start),
    .data_result    (res),
    .data_remainder (rem),
    .data_exception (exc),
    .data_resultRDY (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      q = 32'd0;
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      e = 1'b0;
    end
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    start    = 1'b1;
    prev_res = res;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ee;
    int          n;
    model(a, b, eq, er, ee);
    n = 1;
    while (!rdy && n < 100) begin
      check({tag, "_hold"}, {32'd0, res}, {32'd0, prev_res});
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), ee ? 64'(EXC_LAT) : 64'd33);
    check({tag, "_quo"}, {32'd0, res}, {32'd0, eq});
    check({tag, "_rem"}, {32'd0, rem}, {32'd0, er});
    check({tag, "_exc"}, {63'd0, exc}, {63'd0, ee});
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {63'd0, rdy}, 64'd0);
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    start_op(a, b);
    finish_op(tag, a, b);
  endtask

  initial begin
    logic        seen;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quo", {32'd0, res}, 64'd0);
    check("rst_rem", {32'd0, rem}, 64'd0);
    check("rst_exc", {63'd0, exc}, 64'd0);
    check("rst_rdy", {63'd0, rdy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div("pos", 32'd100, 32'd7);
    do_div("negA", 32'hFFFF_FF9C, 32'd7);
    do_div("negB", 32'd100, 32'hFFFF_FFF9);
    do_div("div0", 32'd5, 32'd0);
    do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("minby1", 32'h8000_0000, 32'd1);
    do_div("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    do_div("minbymin", 32'h8000_0000, 32'h8000_0000);
    do_div("zeroA", 32'd0, 32'hFFFF_FFFD);

    start_op(32'd1000, 32'd10);
    seen = 1'b0;
    repeat (13) begin
      @(posedge clk);
      #1;
      if (rdy) seen = 1'b1;
    end
    check("restart_early_rdy", {63'd0, seen}, 64'd0);
    start_op(32'd9, 32'd4);
    finish_op("restart", 32'd9, 32'd4);

    do_div("prerst", 32'd100, 32'd7);
    start_op(32'd12345, 32'd67);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_quo", {32'd0, res}, 64'd0);
    check("arst_rem", {32'd0, rem}, 64'd0);
    check("arst_exc", {63'd0, exc}, 64'd0);
    check("arst_rdy", {63'd0, rdy}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rdy) seen = 1'b1;
    end
    check("arst_no_rdy", {63'd0, seen}, 64'd0);
    do_div("postrst", 32'd12345, 32'd67);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = -32'($urandom_range(1, 15));
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = ra >> $urandom_range(0, 31);
      do_div("rand", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative signed 32-bit integer divider: the inverse-operation companion to the processor's iterative multiplier, using the same start-pulse / ready-pulse handshake.
- Sits in the multdiv unit beside the multiplier. The processor pulses ctrl_DIV, stalls, and captures the quotient when data_resultRDY pulses.
- Uses a restoring shift-subtract datapath on operand magnitudes, with a sign fixup at the end.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- data_operandA  input  WIDTH  dividend (two's complement)
- data_operandB  input  WIDTH  divisor (two's complement)
- ctrl_DIV  input  1  start pulse; operands are sampled on the same edge
- data_result  output  WIDTH  quotient, truncated toward zero
- data_remainder  output  WIDTH  remainder; sign follows the dividend
- data_exception  output  1  divide-by-zero or overflow (0x80000000 / -1)
- data_resultRDY  output  1  one-cycle pulse: results valid

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, all datapath registers 0.
  - data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0.
  - Reset mid-operation aborts the operation; no RDY pulse is issued.
- States: IDLE, RUN, DONE.
- Start (edge E0, ctrl_DIV=1, any state):
  - Latch |A|, |B|, signA, signA^signB.
  - Latch exception = (B==0) | (A==0x80000000 & B==0xFFFFFFFF).
  - Clear the 32-bit partial remainder; counter=0; next state RUN.
  - ctrl_DIV in RUN or DONE aborts the current operation and restarts it with the new operands.
  - Operands are not required to be held after E0.
- RUN, each edge:
  - {R,Q} shifted left by 1.
  - T = R_shifted - |B|, computed 33 bits wide.
  - If T is non-negative: R=T and Q[0]=1; else R is kept and Q[0]=0.
  - counter++.
  - On the edge where counter reaches WIDTH-1→WIDTH (edge E32): next state DONE, and output registers load the fixed-up values.
- Fixup:
  - quotient = neg ? -Q : Q.
  - remainder = signA ? -R : R.
  - If exception: quotient=0, remainder=0, data_exception=1.
- DONE (exactly one cycle):
  - data_resultRDY=1, decoded from the state register with no combinational path from inputs.
  - Next edge returns to IDLE, unless ctrl_DIV=1, in which case go to RUN.
- Latency: ctrl_DIV sampled at E0 → data_resultRDY high during the cycle after E32 (WIDTH+1 cycles to RDY).
- data_result, data_remainder and data_exception hold their values from DONE until the next DONE or reset. They do not glitch during RUN.
- Negation of |0x80000000| yields 0x80000000. Treat it as unsigned 2^31; the 33-bit subtract handles this correctly.
- No RDY pulse is generated without a preceding ctrl_DIV.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined: when exception is detected at E0, the next state is DONE directly (RDY in the cycle after E0, with quotient 0, remainder 0, exception 1). Non-exception latency is unchanged.
- Undefined: exception cases run the full WIDTH iterations, giving uniform WIDTH+1-cycle latency, and produce the same final outputs.

Test Plan:
- A=100, B=7, pulse ctrl_DIV → RDY exactly 33 cycles later (single cycle); result=14, remainder=2, exception=0.
- A=-100 (0xFFFFFF9C), B=7 → result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Also A=100, B=-7 → result=-14, remainder=2.
- A=5, B=0 → exception=1, result=0, remainder=0. RDY at cycle 33 without DIV_EARLY_EXIT_EN, at cycle 1 with it.
- Boundary cases:
  - A=0x80000000, B=0xFFFFFFFF → exception=1, result=0.
  - A=0x80000000, B=1 → result=0x80000000, exception=0.
  - A=0x7FFFFFFF, B=0x7FFFFFFF → result=1, remainder=0.
- Restart: start 1000/10, pulse ctrl_DIV again at cycle 15 with 9/4 → exactly one RDY, 33 cycles after the second pulse; result=2, remainder=1.
- Reset mid-operation: drive reset=0 asynchronously at cycle 10 of a divide → all outputs 0 immediately, state IDLE, no RDY afterwards. A fresh start after release then completes normally.
